// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded integer register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xlen_t;

    // An address names real, writable state only if it is in range and is not a hardwired zero.
    function automatic logic addr_legal(input int unsigned addr, input int unsigned nregs,
                                        input logic zero_reg);
        return (addr < nregs) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one flop per register, updated on the clock edge; no backpressure.
// Priority within a cycle: flush clears everything, otherwise a set (issue) beats a clear (writeback).
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_vld,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_vld,
    input  logic [AW-1:0]    clr_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    // Callers only assert the valids for in-range addresses, so the shifts never fall off the end.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_vld) begin
            set_mask = NREGS'(1) << set_addr;
        end
        if (clr_vld) begin
            clr_mask = NREGS'(1) << clr_addr;
        end
        if (flush) begin
            busy_d = '0;
        end else begin
            busy_d = (busy_q & ~clr_mask) | set_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/pipe_regfile_sb.sv
// Multi-read-port register file with busy scoreboard; writes/issues land on the clock edge, reads are combinational.
// Build option REGFILE_BYPASS_EN forwards a same-cycle writeback to matching read ports.
module pipe_regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREGS    = NREGS_DEF,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_addr,
    input  logic              flush,
    output logic [NREGS-1:0]  busy_vec
);

    localparam logic ZR = (ZERO_REG != 0);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_ok;
    logic            issue_ok;

    assign wr_ok    = wr_en && addr_legal(32'(wr_addr), NREGS, ZR);
    assign issue_ok = issue_en && !flush && addr_legal(32'(issue_addr), NREGS, ZR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_vld  (issue_ok),
        .set_addr (issue_addr),
        .clr_vld  (wr_ok),
        .clr_addr (wr_addr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    // Illegal addresses (out of range, or a hardwired zero) read as data 0, not busy.
    always_comb begin
        logic [AW-1:0] ra;
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*AW +: AW];
            if (addr_legal(32'(ra), NREGS, ZR)) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (wr_addr == ra)) begin
                    rd_data[i*XLEN +: XLEN] = wr_data;
                    rd_busy[i]              = 1'b0;
                end else begin
                    rd_data[i*XLEN +: XLEN] = regs_q[ra];
                    rd_busy[i]              = busy_vec[ra];
                end
`else
                rd_data[i*XLEN +: XLEN] = regs_q[ra];
                rd_busy[i]              = busy_vec[ra];
`endif
            end
        end
    end

endmodule
